// File: rtl/trigger_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : trigger_sequencer_if
//  Purpose  : Configuration, matcher and status bundle between the
//             multi-stage trigger sequencer and its surroundings.
//  Revision : 1.0  initial release
// ============================================================================
interface trigger_sequencer_if #(
  parameter int pCOUNTER_WIDTH = 16,
  parameter int pREPEAT_WIDTH  = 8
);
  // Control and matcher inputs to the sequencer
  logic                      I_arm;
  logic                      I_disarm;
  logic [3:0]                I_match;
  logic [1:0]                I_stage_count;
  logic [7:0]                I_stage_sel;
  logic [pCOUNTER_WIDTH-1:0] I_window;
  logic [pCOUNTER_WIDTH-1:0] I_holdoff;
  logic [pREPEAT_WIDTH-1:0]  I_repeat;
  logic                      I_capturing;

  // Status and trigger outputs from the sequencer
  logic                      O_trigger_enable;
  logic                      O_match;
  logic                      O_timeout;
  logic [1:0]                O_stage;
  logic [1:0]                O_state;
  logic [pREPEAT_WIDTH-1:0]  O_trigger_count;
  logic                      O_done;

  // Sequencer side
  modport slave (
    input  I_arm, I_disarm, I_match, I_stage_count, I_stage_sel,
           I_window, I_holdoff, I_repeat, I_capturing,
    output O_trigger_enable, O_match, O_timeout, O_stage, O_state,
           O_trigger_count, O_done
  );

  // Controller / stimulus side
  modport master (
    output I_arm, I_disarm, I_match, I_stage_count, I_stage_sel,
           I_window, I_holdoff, I_repeat, I_capturing,
    input  O_trigger_enable, O_match, O_timeout, O_stage, O_state,
           O_trigger_count, O_done
  );
endinterface
`default_nettype wire

// File: rtl/trigger_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : trigger_sequencer
//  Purpose  : Multi-stage trigger controller. Requires up to four matcher
//             events in a programmed order, each within a window of the
//             previous one, then emits one final match pulse, applies a
//             holdoff and repeats until the programmed trigger count.
//  Revision : 1.0  initial release
// ============================================================================
module trigger_sequencer #(
  parameter int pCOUNTER_WIDTH = 16,
  parameter int pREPEAT_WIDTH  = 8
) (
  input  wire               fe_clk,
  input  wire               reset_i,
  trigger_sequencer_if.slave bus
);

  localparam int CW = pCOUNTER_WIDTH;
  localparam int RW = pREPEAT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_HOLDOFF = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Sequencer state
  state_t        r_state,   w_state_nxt;
  logic [1:0]    r_stage,   w_stage_nxt;
  logic [CW-1:0] r_win_cnt, w_win_cnt_nxt;
  logic [CW-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [RW-1:0] r_count,   w_count_nxt;
  logic          r_match,   w_match_nxt;
  logic          r_timeout, w_timeout_nxt;

  // Configuration captured at arm time
  logic [1:0]    r_cfg_stage_count, w_cfg_stage_count_nxt;
  logic [7:0]    r_cfg_sel,         w_cfg_sel_nxt;
  logic [CW-1:0] r_cfg_window,      w_cfg_window_nxt;
  logic [CW-1:0] r_cfg_holdoff,     w_cfg_holdoff_nxt;
  logic [RW-1:0] r_cfg_repeat,      w_cfg_repeat_nxt;

  // Derived per-cycle conditions
  logic [1:0]    w_sel_idx;
  logic          w_hit;
  logic          w_win_active;
  logic          w_win_expired;
  logic          w_hold_done;
  logic [RW-1:0] w_count_inc;

  // Matcher selected by the current stage, window/holdoff completion, saturating count
  always_comb begin
    w_sel_idx     = r_cfg_sel[{r_stage, 1'b0} +: 2];
    w_hit         = bus.I_match[w_sel_idx];
    w_win_active  = (r_stage != 2'd0) && (r_cfg_window != '0);
    w_win_expired = w_win_active && (r_win_cnt == (r_cfg_window - CW'(1)));
    // Holdoff is only entered with a non-zero holdoff, so holdoff-1 cannot wrap there
    w_hold_done   = (r_hold_cnt >= (r_cfg_holdoff - CW'(1)));
    w_count_inc   = (r_count == {RW{1'b1}}) ? r_count : (r_count + RW'(1));
  end

  // Next-state and datapath update; disarm beats arm beats match beats window expiry
  always_comb begin
    w_state_nxt           = r_state;
    w_stage_nxt           = r_stage;
    w_win_cnt_nxt         = r_win_cnt;
    w_hold_cnt_nxt        = r_hold_cnt;
    w_count_nxt           = r_count;
    w_match_nxt           = 1'b0;
    w_timeout_nxt         = 1'b0;
    w_cfg_stage_count_nxt = r_cfg_stage_count;
    w_cfg_sel_nxt         = r_cfg_sel;
    w_cfg_window_nxt      = r_cfg_window;
    w_cfg_holdoff_nxt     = r_cfg_holdoff;
    w_cfg_repeat_nxt      = r_cfg_repeat;

    if (bus.I_disarm) begin
      // Abort; the trigger count is left visible for software
      w_state_nxt    = ST_IDLE;
      w_stage_nxt    = 2'd0;
      w_win_cnt_nxt  = '0;
      w_hold_cnt_nxt = '0;
    end else if (bus.I_arm) begin
      // Arm from any state restarts with freshly latched configuration
      w_cfg_stage_count_nxt = bus.I_stage_count;
      w_cfg_sel_nxt         = bus.I_stage_sel;
      w_cfg_window_nxt      = bus.I_window;
      w_cfg_holdoff_nxt     = bus.I_holdoff;
      w_cfg_repeat_nxt      = bus.I_repeat;
      w_state_nxt           = ST_WAIT;
      w_stage_nxt           = 2'd0;
      w_win_cnt_nxt         = '0;
      w_hold_cnt_nxt        = '0;
      w_count_nxt           = '0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (w_hit) begin
            w_win_cnt_nxt = '0;
            if (r_stage < r_cfg_stage_count) begin
              w_stage_nxt = r_stage + 2'd1;
            end else begin
              // Final stage matched: fire and decide where to go next
              w_match_nxt = 1'b1;
              w_count_nxt = w_count_inc;
              w_stage_nxt = 2'd0;
              if ((r_cfg_repeat != '0) && (w_count_inc == r_cfg_repeat)) begin
                w_state_nxt = ST_DONE;
              end else if (r_cfg_holdoff == '0) begin
                w_state_nxt = ST_WAIT;
              end else begin
                w_state_nxt    = ST_HOLDOFF;
                w_hold_cnt_nxt = '0;
              end
            end
          end else if (w_win_active) begin
            if (w_win_expired) begin
              // Too slow between stages: fall back to the first stage
              w_stage_nxt   = 2'd0;
              w_win_cnt_nxt = '0;
              w_timeout_nxt = 1'b1;
            end else begin
              w_win_cnt_nxt = r_win_cnt + CW'(1);
            end
          end
        end
        ST_HOLDOFF: begin
          // Leave only once the holdoff has elapsed and capture has finished
          if (w_hold_done && !bus.I_capturing) begin
            w_state_nxt    = ST_WAIT;
            w_stage_nxt    = 2'd0;
            w_hold_cnt_nxt = '0;
          end else if (!w_hold_done) begin
            w_hold_cnt_nxt = r_hold_cnt + CW'(1);
          end
        end
        default: begin
          // IDLE and DONE hold until arm or disarm
        end
      endcase
    end
  end

  // State, counter and configuration registers
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      r_state           <= ST_IDLE;
      r_stage           <= 2'd0;
      r_win_cnt         <= '0;
      r_hold_cnt        <= '0;
      r_count           <= '0;
      r_match           <= 1'b0;
      r_timeout         <= 1'b0;
      r_cfg_stage_count <= 2'd0;
      r_cfg_sel         <= 8'd0;
      r_cfg_window      <= '0;
      r_cfg_holdoff     <= '0;
      r_cfg_repeat      <= '0;
    end else begin
      r_state           <= w_state_nxt;
      r_stage           <= w_stage_nxt;
      r_win_cnt         <= w_win_cnt_nxt;
      r_hold_cnt        <= w_hold_cnt_nxt;
      r_count           <= w_count_nxt;
      r_match           <= w_match_nxt;
      r_timeout         <= w_timeout_nxt;
      r_cfg_stage_count <= w_cfg_stage_count_nxt;
      r_cfg_sel         <= w_cfg_sel_nxt;
      r_cfg_window      <= w_cfg_window_nxt;
      r_cfg_holdoff     <= w_cfg_holdoff_nxt;
      r_cfg_repeat      <= w_cfg_repeat_nxt;
    end
  end

  // Enable stays up through the match cycle so the trigger block sees it with the pulse
  assign bus.O_trigger_enable = (r_state == ST_WAIT) || r_match;
  assign bus.O_match          = r_match;
  assign bus.O_timeout        = r_timeout;
  assign bus.O_stage          = r_stage;
  assign bus.O_state          = r_state;
  assign bus.O_trigger_count  = r_count;
  assign bus.O_done           = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_trigger_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trigger_sequencer
//  Purpose  : Directed self-checking bench for trigger_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_trigger_sequencer;

  logic fe_clk  = 1'b0;
  logic reset_i = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  trigger_sequencer_if #(.pCOUNTER_WIDTH(16), .pREPEAT_WIDTH(8)) bus ();

  trigger_sequencer #(.pCOUNTER_WIDTH(16), .pREPEAT_WIDTH(8)) dut (
    .fe_clk  (fe_clk),
    .reset_i (reset_i),
    .bus     (bus.slave)
  );

  always #5 fe_clk = ~fe_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then stable and new inputs may be driven
  task automatic tick();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_cfg(input logic [1:0] sc, input logic [7:0] sel, input logic [15:0] win,
                         input logic [15:0] hold, input logic [7:0] rep);
    bus.I_stage_count = sc;
    bus.I_stage_sel   = sel;
    bus.I_window      = win;
    bus.I_holdoff     = hold;
    bus.I_repeat      = rep;
  endtask

  task automatic arm();
    bus.I_arm = 1'b1;
    tick();
    bus.I_arm = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] m);
    bus.I_match = m;
    tick();
    bus.I_match = 4'b0000;
  endtask

  int hcyc;
  int bad_hold;

  initial begin
    bus.I_arm = 0; bus.I_disarm = 0; bus.I_match = 0; bus.I_capturing = 0;
    set_cfg(2'd0, 8'h00, 16'd0, 16'd0, 8'd0);

    // Reset state
    idle(3);
    chk("rst_state", bus.O_state, 0);
    chk("rst_en",    bus.O_trigger_enable, 0);
    chk("rst_count", bus.O_trigger_count, 0);
    chk("rst_done",  bus.O_done, 0);
    reset_i = 1'b0;
    tick();
    chk("idle_state", bus.O_state, 0);

    // Single stage on matcher 2, repeat 1
    set_cfg(2'd0, 8'h02, 16'd0, 16'd0, 8'd1);
    arm();
    chk("t1_arm_state", bus.O_state, 1);
    chk("t1_arm_en",    bus.O_trigger_enable, 1);
    pulse(4'b1011);
    chk("t1_nonsel_match", bus.O_match, 0);
    pulse(4'b0100);
    chk("t1_match",  bus.O_match, 1);
    chk("t1_count",  bus.O_trigger_count, 1);
    chk("t1_done",   bus.O_done, 1);
    chk("t1_en_matchcyc", bus.O_trigger_enable, 1);
    tick();
    chk("t1_match_off", bus.O_match, 0);
    chk("t1_en_off",    bus.O_trigger_enable, 0);
    chk("t1_done_hold", bus.O_done, 1);

    // Three stages 0->1->3, window 10, 3-cycle gaps
    set_cfg(2'd2, 8'h34, 16'd10, 16'd0, 8'd0);
    arm();
    chk("t2_arm_count", bus.O_trigger_count, 0);
    pulse(4'b0001);
    chk("t2_stage1", bus.O_stage, 1);
    idle(2);
    pulse(4'b0010);
    chk("t2_stage2", bus.O_stage, 2);
    idle(2);
    pulse(4'b1000);
    chk("t2_match", bus.O_match, 1);
    chk("t2_count", bus.O_trigger_count, 1);
    chk("t2_state", bus.O_state, 1);
    chk("t2_stage0", bus.O_stage, 0);
    tick();
    chk("t2_match_off", bus.O_match, 0);

    // Same sequence with an 11-cycle gap before the last stage
    pulse(4'b0001);
    idle(2);
    pulse(4'b0010);
    idle(9);
    chk("t2_pre_expiry_stage",   bus.O_stage, 2);
    chk("t2_pre_expiry_timeout", bus.O_timeout, 0);
    tick();
    chk("t2_timeout", bus.O_timeout, 1);
    chk("t2_timeout_stage", bus.O_stage, 0);
    chk("t2_timeout_nomatch", bus.O_match, 0);
    pulse(4'b1000);
    chk("t2_late_nomatch", bus.O_match, 0);
    chk("t2_late_timeout", bus.O_timeout, 0);
    chk("t2_late_count", bus.O_trigger_count, 1);

    // Match exactly on the expiry cycle wins
    pulse(4'b0001);
    idle(9);
    pulse(4'b0010);
    chk("t3_stage", bus.O_stage, 2);
    chk("t3_no_timeout", bus.O_timeout, 0);
    pulse(4'b1000);
    chk("t3_no_timeout2", bus.O_timeout, 0);
    chk("t3_match", bus.O_match, 1);
    chk("t3_count", bus.O_trigger_count, 2);

    // Holdoff 5 with capture held high for 8 cycles from the final match
    set_cfg(2'd0, 8'h00, 16'd0, 16'd5, 8'd0);
    arm();
    chk("t4_arm_count", bus.O_trigger_count, 0);
    bus.I_capturing = 1'b1;
    pulse(4'b0001);
    chk("t4_match", bus.O_match, 1);
    chk("t4_state", bus.O_state, 2);
    chk("t4_en_matchcyc", bus.O_trigger_enable, 1);
    hcyc = 0;
    bad_hold = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.O_state != 2'd2) break;
      hcyc++;
      if (i > 0 && (bus.O_match !== 1'b0 || bus.O_trigger_enable !== 1'b0)) bad_hold++;
      bus.I_capturing = (i < 7);
      bus.I_match     = (i == 1) ? 4'b0001 : 4'b0000;
      tick();
    end
    bus.I_match = 4'b0000;
    bus.I_capturing = 1'b0;
    chk("t4_holdoff_len", hcyc, 8);
    chk("t4_holdoff_quiet", bad_hold, 0);
    chk("t4_back_wait", bus.O_state, 1);
    chk("t4_en_back", bus.O_trigger_enable, 1);
    chk("t4_match_ignored", bus.O_trigger_count, 1);

    // Disarm coincident with the final match of a two-stage sequence
    set_cfg(2'd1, 8'h04, 16'd0, 16'd0, 8'd0);
    arm();
    pulse(4'b0001);
    pulse(4'b0010);
    chk("t5_first_count", bus.O_trigger_count, 1);
    tick();
    pulse(4'b0001);
    chk("t5_stage1", bus.O_stage, 1);
    bus.I_disarm = 1'b1;
    pulse(4'b0010);
    bus.I_disarm = 1'b0;
    chk("t5_idle", bus.O_state, 0);
    chk("t5_nomatch", bus.O_match, 0);
    chk("t5_count_kept", bus.O_trigger_count, 1);
    chk("t5_en", bus.O_trigger_enable, 0);

    // Re-arm in WAIT: new config inputs have no effect until arm
    arm();
    pulse(4'b0001);
    pulse(4'b0010);
    chk("t5b_count", bus.O_trigger_count, 1);
    set_cfg(2'd0, 8'h03, 16'd0, 16'd0, 8'd1);
    pulse(4'b0001);
    chk("t5b_old_cfg", bus.O_stage, 1);
    arm();
    chk("t5b_rearm_count", bus.O_trigger_count, 0);
    chk("t5b_rearm_stage", bus.O_stage, 0);
    chk("t5b_rearm_state", bus.O_state, 1);
    pulse(4'b0001);
    chk("t5b_new_cfg_ignore", bus.O_stage, 0);
    chk("t5b_new_cfg_nomatch", bus.O_match, 0);
    pulse(4'b1000);
    chk("t5b_new_match", bus.O_match, 1);
    chk("t5b_new_done", bus.O_done, 1);

    // Asynchronous reset in the middle of holdoff
    set_cfg(2'd0, 8'h00, 16'd0, 16'd20, 8'd0);
    arm();
    pulse(4'b0001);
    idle(2);
    chk("t6_in_holdoff", bus.O_state, 2);
    #2;
    reset_i = 1'b1;
    #1;
    chk("t6_rst_state", bus.O_state, 0);
    chk("t6_rst_count", bus.O_trigger_count, 0);
    chk("t6_rst_en",    bus.O_trigger_enable, 0);
    chk("t6_rst_match", bus.O_match, 0);
    tick();
    reset_i = 1'b0;
    tick();
    chk("t6_post_state", bus.O_state, 0);
    chk("t6_post_done",  bus.O_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trigger_sequencer.md
# trigger_sequencer

Multi-stage trigger controller that sits in front of the simple trigger block in the front-end clock domain. It arms and disarms triggering. It requires up to four pattern-match events to occur in a programmed order within a per-stage window, then issues a single final match pulse to the trigger/capture path. It then enforces a holdoff and repeats until a programmed trigger count is reached.

## Interface
- pCOUNTER_WIDTH, 16, width of window and holdoff counters
- pREPEAT_WIDTH, 8, width of repeat count and trigger counter
- fe_clk  in  1  front-end clock; all logic on rising edge
- reset_i  in  1  asynchronous, active-high reset
- I_arm  in  1  single-cycle pulse: latch config, start sequence
- I_disarm  in  1  single-cycle pulse: abort to IDLE
- I_match  in  4  pattern-match flags from the four matchers, one cycle per event
- I_stage_count  in  2  number of stages minus 1 (0 = single stage)
- I_stage_sel  in  8  matcher index per stage; bits [2k+1:2k] select the matcher for stage k
- I_window  in  pCOUNTER_WIDTH  max cycles allowed between stages; 0 = unlimited
- I_holdoff  in  pCOUNTER_WIDTH  cycles to suppress triggering after each trigger
- I_repeat  in  pREPEAT_WIDTH  triggers before DONE; 0 = unlimited
- I_capturing  in  1  capture-in-progress flag from the capture block
- O_trigger_enable  out  1  enable to the trigger block
- O_match  out  1  registered final-stage match pulse to the trigger block
- O_timeout  out  1  one-cycle pulse on stage-window expiry
- O_stage  out  2  current stage index
- O_state  out  2  IDLE=0, WAIT=1, HOLDOFF=2, DONE=3
- O_trigger_count  out  pREPEAT_WIDTH  triggers issued since arm; saturates at all-ones
- O_done  out  1  high in DONE

## Operation
- All outputs are 0 during and after reset. Internal counters and latched config reset to 0.
- Config inputs (stage_count, stage_sel, window, holdoff, repeat) are latched on I_arm. Changes while armed have no effect.
- Priority each cycle: I_disarm > I_arm > match > window expiry.
- IDLE: I_arm -> WAIT. Stage=0, window counter=0, trigger count=0.
- WAIT: samples I_match[sel(stage)]. Matches on non-selected matchers are ignored.
  - Match with stage < stage_count: stage+1, window counter cleared.
  - Match with stage == stage_count: O_match=1 next cycle, trigger count+1, stage=0.
    - If repeat != 0 and the new count == repeat -> DONE.
    - Else if holdoff == 0 -> stays in WAIT.
    - Else -> HOLDOFF.
  - Window: counts only while stage > 0 and window != 0. When the counter reaches window-1 with no match, stage returns to 0 and O_timeout pulses. A match in the expiry cycle wins, and no timeout occurs.
- HOLDOFF: the counter counts holdoff cycles. The state exits to WAIT (stage 0) on the first cycle where the count is complete and I_capturing == 0. While I_capturing is high, the block stays in HOLDOFF.
- DONE: holds count and O_done. I_arm re-arms (fresh config, count cleared). I_disarm -> IDLE.
- I_disarm in any state -> IDLE next cycle; O_trigger_count retains its value.
- I_arm while already armed restarts the sequence: WAIT, stage 0, count cleared, new config.

## Timing
- O_trigger_enable is 1 in WAIT and during the O_match cycle. It is 0 otherwise, including in HOLDOFF and DONE.
- The trigger block registers its enable, so O_trigger_enable must be high at least one cycle before O_match. This holds because arm-to-WAIT takes one cycle and a match is sampled only in WAIT.
- Arm latency: I_arm at edge N -> O_state=WAIT and O_trigger_enable=1 after edge N.
- Match latency: final match sampled at edge N -> O_match high for exactly one cycle after edge N. O_trigger_count updates at the same edge.
- Holdoff of H cycles: O_state=HOLDOFF for exactly H cycles when I_capturing is low. O_trigger_enable returns one cycle after holdoff ends.
- O_timeout and O_match never assert in the same cycle.

## Test plan
- Single stage, sel=2, repeat=1: arm, pulse I_match[2] -> one O_match pulse one cycle later; count=1; O_done=1; O_trigger_enable=0 after that cycle.
- Three stages, sel=0→1→3, window=10: matches at 3-cycle gaps -> one O_match. Repeat with an 11-cycle gap before stage 2 -> O_timeout pulse, stage=0, no O_match.
- Match on the exact window-expiry cycle -> stage advances, no O_timeout.
- Holdoff=5, repeat=0, I_capturing held high 8 cycles after the trigger -> HOLDOFF lasts 8 cycles, then WAIT; matches during HOLDOFF are ignored.
- I_disarm mid-stage 1 coincident with the final match -> IDLE, no O_match, count unchanged. I_arm while in WAIT re-latches config and clears count.
- Assert reset_i asynchronously mid-HOLDOFF -> all outputs 0 immediately, state IDLE after release.
